// File: rtl/beat_timer_pkg.sv
// Shared constants for the beat timer: channel mode encodings and default widths.
package beat_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEF_CNT_W = 28;
  localparam int DEF_PRE_W = 8;

endpackage

// File: rtl/beat_timer_chan.sv
// One beat channel: latched period/mode, tick counter, running flag,
// registered finish pulse and sticky pending flag.
module beat_chan
  import beat_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic_in,
  input  logic [CNT_W-1:0] period_in,
  input  logic             pend_clr,
  output logic             running,
  output logic             beat_finish,
  output logic             beat_pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             run_q, run_d;
  logic             fin_q, fin_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] last_s;

  // Final count of a beat; a zero period behaves like a period of one.
  always_comb begin
    if (per_q == {CNT_W{1'b0}}) begin
      last_s = {CNT_W{1'b0}};
    end else begin
      last_s = per_q - CNT_W'(1);
    end
  end

  // Next-state logic; stop beats start, and a restart discards the beat in flight.
  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    mode_d = mode_q;
    run_d  = run_q;
    fin_d  = 1'b0;
    if (stop) begin
      run_d = 1'b0;
      cnt_d = {CNT_W{1'b0}};
    end else if (start) begin
      per_d  = period_in;
      mode_d = periodic_in;
      cnt_d  = {CNT_W{1'b0}};
      run_d  = 1'b1;
    end else if (run_q && tick) begin
      if (cnt_q >= last_s) begin
        cnt_d = {CNT_W{1'b0}};
        fin_d = 1'b1;
        run_d = (mode_q == MODE_PERIODIC);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    pend_d = fin_d | (pend_q & ~pend_clr);
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      per_q  <= {CNT_W{1'b0}};
      mode_q <= MODE_ONESHOT;
      run_q  <= 1'b0;
      fin_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      run_q  <= run_d;
      fin_q  <= fin_d;
      pend_q <= pend_d;
    end
  end

  assign running      = run_q;
  assign beat_finish  = fin_q;
  assign beat_pending = pend_q;

endmodule

// File: rtl/beat_timer.sv
// Multi-channel beat timer: shared prescaler, CH beat channels and a
// registered music interrupt built from the masked pending flags.
module beat_timer
  import beat_timer_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PRE_W-1:0]    prescale,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       stop,
  input  logic [CH-1:0]       periodic,
  input  logic [CH*CNT_W-1:0] period,
  input  logic [CH-1:0]       pend_clr,
  input  logic [CH-1:0]       irq_mask,
  output logic [CH-1:0]       running,
  output logic [CH-1:0]       beat_finish,
  output logic [CH-1:0]       beat_pending,
  output logic                music_interrupt
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_s;
  logic             irq_q, irq_d;

  // The >= compare lets a lowered prescale take effect without a long wrap.
  always_comb begin
    tick_s = en && (pre_cnt_q >= prescale);
    if (!en) begin
      pre_cnt_d = pre_cnt_q;
    end else if (tick_s) begin
      pre_cnt_d = {PRE_W{1'b0}};
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
    irq_d = |(beat_pending & irq_mask);
  end

  // Prescaler count and interrupt register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= {PRE_W{1'b0}};
      irq_q     <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign music_interrupt = irq_q;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    beat_chan #(.CNT_W(CNT_W)) u_chan (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick_s),
      .start        (start[gi]),
      .stop         (stop[gi]),
      .periodic_in  (periodic[gi]),
      .period_in    (period[gi*CNT_W +: CNT_W]),
      .pend_clr     (pend_clr[gi]),
      .running      (running[gi]),
      .beat_finish  (beat_finish[gi]),
      .beat_pending (beat_pending[gi])
    );
  end

endmodule

// File: tb/tb_beat_timer.sv
// Self-checking bench for beat_timer: a remaining-ticks reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_beat_timer;

  localparam int CH    = 4;
  localparam int CNT_W = 28;
  localparam int PRE_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b1;
  logic [PRE_W-1:0]    prescale = '0;
  logic [CH-1:0]       start = '0, stop = '0, periodic = '0, pend_clr = '0, irq_mask = '0;
  logic [CH*CNT_W-1:0] period = '0;
  logic [CH-1:0]       running, beat_finish, beat_pending;
  logic                music_interrupt;

  // small-width instance for the all-ones period boundary
  logic       en4 = 1'b1;
  logic [3:0] prescale4 = '0;
  logic [0:0] start4 = '0, stop4 = '0, periodic4 = '0, pend_clr4 = '0, irq_mask4 = '0;
  logic [3:0] period4 = '0;
  logic [0:0] running4, beat_finish4, beat_pending4;
  logic       music_interrupt4;

  int checks = 0;
  int failures = 0;

  // reference model: ticks remaining until the next beat per channel
  int          m_elapsed;
  int unsigned m_left [CH];
  int unsigned m_len  [CH];
  logic [CH-1:0] m_run, m_per, m_pend, m_fin;
  logic          m_irq;

  always #5 clk = ~clk;

  beat_timer #(.CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .start(start), .stop(stop),
    .periodic(periodic), .period(period), .pend_clr(pend_clr), .irq_mask(irq_mask),
    .running(running), .beat_finish(beat_finish), .beat_pending(beat_pending),
    .music_interrupt(music_interrupt)
  );

  beat_timer #(.CH(1), .CNT_W(4), .PRE_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .prescale(prescale4), .start(start4), .stop(stop4),
    .periodic(periodic4), .period(period4), .pend_clr(pend_clr4), .irq_mask(irq_mask4),
    .running(running4), .beat_finish(beat_finish4), .beat_pending(beat_pending4),
    .music_interrupt(music_interrupt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0;
    m_run = '0; m_per = '0; m_pend = '0; m_fin = '0; m_irq = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_left[i] = 0;
      m_len[i]  = 1;
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    bit tk;
    int unsigned p;
    if (rst) begin
      model_reset();
      return;
    end
    tk = en && (m_elapsed >= int'(prescale));
    if (en) m_elapsed = tk ? 0 : m_elapsed + 1;
    m_irq = |(m_pend & irq_mask);
    for (int i = 0; i < CH; i++) begin
      m_fin[i] = 1'b0;
      if (stop[i]) begin
        m_run[i] = 1'b0;
      end else if (start[i]) begin
        p = period[i*CNT_W +: CNT_W];
        m_len[i]  = (p == 0) ? 1 : p;
        m_left[i] = m_len[i];
        m_per[i]  = periodic[i];
        m_run[i]  = 1'b1;
      end else if (m_run[i] && tk) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_fin[i] = 1'b1;
          if (m_per[i]) m_left[i] = m_len[i];
          else m_run[i] = 1'b0;
        end
      end
      m_pend[i] = m_fin[i] | (m_pend[i] & ~pend_clr[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("running", 64'(running), 64'(m_run));
    chk("beat_finish", 64'(beat_finish), 64'(m_fin));
    chk("beat_pending", 64'(beat_pending), 64'(m_pend));
    chk("music_interrupt", 64'(music_interrupt), 64'(m_irq));
  endtask

  task automatic set_period(input int ch, input int unsigned val);
    period[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  // Steps until beat_finish[ch]; n is the number of steps, or -1 on timeout.
  task automatic wait_finish(input int ch, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (beat_finish[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n, tot;
    int stamps [4];
    int cnt [CH];
    model_reset();

    // reset state
    step(); step();
    chk("reset_outputs", 64'({running, beat_finish, beat_pending, music_interrupt}), 64'd0);
    rst = 1'b0;
    irq_mask = 4'b1111;
    step();

    // one-shot CH0 P=5 prescale=0
    set_period(0, 5); periodic[0] = 1'b0; start[0] = 1'b1;
    step(); start[0] = 1'b0;
    wait_finish(0, 20, n);
    chk("oneshot_latency", 64'(n), 64'd5);
    chk("oneshot_running_drop", 64'(running[0]), 64'd0);
    chk("oneshot_pending", 64'(beat_pending[0]), 64'd1);
    chk("oneshot_irq_not_yet", 64'(music_interrupt), 64'd0);
    step();
    chk("oneshot_irq", 64'(music_interrupt), 64'd1);

    // periodic CH1 P=3 prescale=2
    prescale = 8'd2; set_period(1, 3); periodic[1] = 1'b1; start[1] = 1'b1;
    step(); start[1] = 1'b0;
    tot = 0;
    for (int j = 0; j < 4; j++) begin
      wait_finish(1, 40, n);
      tot += n;
      stamps[j] = (n < 0) ? -1000 : tot;
    end
    for (int j = 0; j < 3; j++) chk("periodic_spacing", 64'(stamps[j+1] - stamps[j]), 64'd9);
    for (int k = 0; k < 4; k++) step();
    stop[1] = 1'b1; step(); stop[1] = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (beat_finish[1]) n++;
    end
    chk("stop_no_pulses", 64'(n), 64'd0);
    chk("stop_running", 64'(running[1]), 64'd0);

    // restart at cnt=2 of P=4
    prescale = 8'd0; set_period(2, 4); periodic[2] = 1'b0; start[2] = 1'b1;
    step(); start[2] = 1'b0;
    step(); step();
    start[2] = 1'b1; step(); start[2] = 1'b0;
    wait_finish(2, 20, n);
    chk("restart_latency", 64'(n), 64'd4);

    // start with stop in the same cycle
    set_period(3, 2); start[3] = 1'b1; stop[3] = 1'b1;
    step(); start[3] = 1'b0; stop[3] = 1'b0;
    chk("start_stop_idle", 64'(running[3]), 64'd0);

    // pend_clr coinciding with a beat: set wins
    set_period(0, 2); periodic[0] = 1'b0; start[0] = 1'b1;
    step(); start[0] = 1'b0; pend_clr[0] = 1'b1;
    step();
    chk("pend_cleared", 64'(beat_pending[0]), 64'd0);
    step();
    chk("pend_set_wins_finish", 64'(beat_finish[0]), 64'd1);
    chk("pend_set_wins", 64'(beat_pending[0]), 64'd1);
    pend_clr[0] = 1'b0;

    // P=0 and P=1 both fire every tick
    set_period(0, 0); set_period(1, 1); periodic[1:0] = 2'b11; start[1:0] = 2'b11;
    step(); start[1:0] = 2'b00;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("p0_p1_every_tick", 64'(beat_finish[1:0]), 64'd3);
    end
    stop[1:0] = 2'b11; step(); stop[1:0] = 2'b00;

    // en low for 10 cycles stretches the beat by 10
    set_period(2, 6); periodic[2] = 1'b0; start[2] = 1'b1;
    step(); start[2] = 1'b0;
    step(); step();
    en = 1'b0;
    for (int k = 0; k < 10; k++) step();
    en = 1'b1;
    wait_finish(2, 30, n);
    chk("en_stretch", 64'(n < 0 ? -1 : n + 12), 64'd16);

    // masked channel sets pending without interrupt
    irq_mask = '0; pend_clr = 4'b1111; step(); pend_clr = '0;
    set_period(3, 1); periodic[3] = 1'b0; start[3] = 1'b1;
    step(); start[3] = 1'b0;
    step(); step();
    chk("masked_pending", 64'(beat_pending[3]), 64'd1);
    chk("masked_no_irq", 64'(music_interrupt), 64'd0);

    // all channels, independent pulse counts
    irq_mask = 4'b1111;
    for (int i = 0; i < CH; i++) begin
      set_period(i, i + 2);
      cnt[i] = 0;
    end
    periodic = 4'b1111; start = 4'b1111;
    step(); start = '0;
    for (int k = 0; k < 60; k++) begin
      step();
      for (int i = 0; i < CH; i++) if (beat_finish[i]) cnt[i]++;
    end
    chk("multi_cnt0", 64'(cnt[0]), 64'd30);
    chk("multi_cnt1", 64'(cnt[1]), 64'd20);
    chk("multi_cnt2", 64'(cnt[2]), 64'd15);
    chk("multi_cnt3", 64'(cnt[3]), 64'd12);

    // async reset mid-run clears outputs within the cycle
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 64'({running, beat_finish, beat_pending, music_interrupt}), 64'd0);
    model_reset();
    step();
    // first tick after release comes prescale+1 enabled cycles later
    prescale = 8'd2; set_period(0, 1); periodic = '0; start[0] = 1'b1;
    rst = 1'b0;
    step(); start[0] = 1'b0;
    wait_finish(0, 20, n);
    chk("post_rst_first_tick", 64'(n < 0 ? -1 : n + 1), 64'd3);

    // all-ones period on the 4-bit build
    prescale = 8'd0;
    period4 = 4'hF; start4 = 1'b1;
    step(); start4 = 1'b0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (beat_finish4[0]) begin
        n = k;
        break;
      end
    end
    chk("cntw4_max_period", 64'(n), 64'd15);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      start = '0; stop = '0; pend_clr = '0;
      for (int i = 0; i < CH; i++) begin
        start[i]    = ($urandom_range(0, 15) == 0);
        stop[i]     = ($urandom_range(0, 39) == 0);
        pend_clr[i] = ($urandom_range(0, 7) == 0);
        periodic[i] = 1'($urandom_range(0, 1));
        set_period(i, $urandom_range(0, 6));
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) prescale = PRE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) irq_mask = CH'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_timer.md
# beat_timer

Multi-channel, parametrised beat timer for the buzzer music subsystem. It generates note-duration ("beat") events for up to CH independent voices. A shared programmable prescaler feeds per-channel period counters. Each channel runs one-shot or periodic and raises a sticky, maskable pending flag, and all pending flags merge into one music interrupt for the game controller. It sits between the music sequencer (which programs periods and starts beats) and the tone generators / CPU interrupt logic.

## Interface
Parameters:
- CH, 4: number of beat channels (1..16)
- CNT_W, 28: per-channel period/counter width
- PRE_W, 8: prescaler width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  global enable; low freezes prescaler and all counters
- prescale  input  PRE_W  tick every prescale+1 enabled clk cycles
- start  input  CH  per-channel start/restart request, sampled each cycle
- stop  input  CH  per-channel stop request
- periodic  input  CH  mode at start: 1 = periodic, 0 = one-shot
- period  input  CH*CNT_W  channel i period in ticks at bits [i*CNT_W +: CNT_W]
- pend_clr  input  CH  clear pending flag
- irq_mask  input  CH  1 = channel contributes to interrupt
- running  output  CH  channel active
- beat_finish  output  CH  one-cycle registered pulse per completed beat
- beat_pending  output  CH  sticky completion flag
- music_interrupt  output  1  registered OR of (beat_pending & irq_mask)

## Operation
- Reset: all outputs 0, prescaler count 0, all channel counters 0, latched periods 0, latched modes one-shot.
- Prescaler: when en=1, pre_cnt increments. When pre_cnt >= prescale, tick=1 that cycle and pre_cnt wraps to 0. The >= compare guarantees recovery when prescale is lowered mid-count. When en=0, tick=0 and pre_cnt holds.
- Channel idle: running=0, counter holds 0.
- start[i]=1 with stop[i]=0: latch period[i] (P) and periodic[i]. Then cnt=0, running=1, regardless of the prior state, so a restart discards the current beat. The start is accepted even when en=0.
- stop[i]=1: running=0, cnt=0, no beat_finish. stop has priority over a simultaneous start.
- While running, on each tick: if cnt >= P-1, the beat completes, cnt goes to 0, beat_finish pulses, and beat_pending sets. One-shot clears running; periodic stays running. Otherwise cnt increments.
- P=0 behaves as P=1, completing on every tick.
- beat_pending clears on pend_clr. A set in the same cycle as a clear wins.
- The period input is not re-read while running. A new period takes effect only at the next start.
- Counter arithmetic wraps modulo 2^CNT_W. It cannot overflow in practice because cnt <= P-1.

## Timing
- start sampled at edge k with prescale=0 and en=1: running=1 after edge k. beat_finish is high for the one cycle following edge k+P.
- Periodic mode, prescale=0: beat_finish pulses every P cycles exactly, with no dead cycle at wrap.
- With prescale=N, beats are P·(N+1) cycles apart. The first-beat latency also includes the current prescaler phase (0..N cycles).
- beat_pending rises in the same cycle as beat_finish.
- music_interrupt rises one cycle after beat_pending. It falls one cycle after pend_clr or after the mask bit clears.
- Asserting rst mid-beat clears everything immediately, with no pulse. The first tick after release is prescale+1 enabled cycles later.

## Structure
- Package beat_timer_pkg: the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1) and the default CNT_W/PRE_W localparams.
- Sub-module beat_chan: one channel (counter, latched period/mode, running, finish, pending), instantiated CH times in a generate loop.
- Top level holds the prescaler and the interrupt OR/register.

## Test plan
- Reset, then one-shot with CH0, P=5, prescale=0: beat_finish[0] pulses once after 5 cycles; running[0] drops in the same cycle; beat_pending[0]=1; music_interrupt=1 one cycle later with mask=1.
- Periodic with CH1, P=3, prescale=2: beat_finish[1] every 9 cycles for 4 beats; stop asserted mid-beat gives no further pulses and running=0.
- Simultaneous events: start+stop in the same cycle leaves the channel idle; pend_clr coinciding with a beat leaves pending=1; a restart at cnt=2 of P=4 delays the finish to 4 ticks after the restart.
- Boundaries: P=0 and P=1 both fire every tick; P=2^CNT_W-1 is checked with a forced small CNT_W=4 build (fires after 15 ticks); en low for 10 cycles stretches the beat by exactly 10 cycles.
- Multi-channel: all CH channels started with different periods; per-channel pulse counts are checked independently; masked channels set pending without raising music_interrupt; async rst mid-run clears all outputs within the same cycle.
